// File: rtl/td4_core.sv
// rtl/td4_core.sv - TD4 4-bit CPU single-cycle execution core
// Decodes the instruction at the PC, runs it through one 4-bit adder and commits on enabled edges.
module td4_core #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       CLK,
    input  logic       N_RESET,
    input  logic       EN,
    input  logic [7:0] D,
    input  logic [3:0] IN,
    output logic [3:0] A,
    output logic [3:0] OUT,
    output logic [3:0] REG_A,
    output logic [3:0] REG_B,
    output logic       CARRY
);

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_A,
        SRC_B,
        SRC_IN
    } src_e;

    typedef enum logic [2:0] {
        DST_NONE,
        DST_A,
        DST_B,
        DST_OUT,
        DST_JMP,
        DST_JNC
    } dst_e;

    logic [3:0] pc_q,    pc_d;
    logic [3:0] reg_a_q, reg_a_d;
    logic [3:0] reg_b_q, reg_b_d;
    logic [3:0] out_q,   out_d;
    logic       carry_q, carry_d;

    logic [3:0] opcode;
    logic [3:0] imm;
    src_e       src_sel;
    dst_e       dst_sel;
    logic [3:0] src_val;
    logic [4:0] sum;
    logic       jump_taken;

    assign opcode = D[7:4];
    assign imm    = D[3:0];

    always_comb begin
        src_sel = SRC_ZERO;
        dst_sel = DST_NONE;
        case (opcode)
            4'b0000: begin src_sel = SRC_A;    dst_sel = DST_A;   end
            4'b0101: begin src_sel = SRC_B;    dst_sel = DST_B;   end
            4'b0011: begin src_sel = SRC_ZERO; dst_sel = DST_A;   end
            4'b0111: begin src_sel = SRC_ZERO; dst_sel = DST_B;   end
            4'b0001: begin src_sel = SRC_B;    dst_sel = DST_A;   end
            4'b0100: begin src_sel = SRC_A;    dst_sel = DST_B;   end
            4'b0010: begin src_sel = SRC_IN;   dst_sel = DST_A;   end
            4'b0110: begin src_sel = SRC_IN;   dst_sel = DST_B;   end
            4'b1001: begin src_sel = SRC_B;    dst_sel = DST_OUT; end
            4'b1011: begin src_sel = SRC_ZERO; dst_sel = DST_OUT; end
            4'b1111: begin src_sel = SRC_ZERO; dst_sel = DST_JMP; end
            4'b1110: begin src_sel = SRC_ZERO; dst_sel = DST_JNC; end
            default: begin src_sel = SRC_ZERO; dst_sel = DST_NONE; end
        endcase
    end

    always_comb begin
        src_val = 4'h0;
        case (src_sel)
            SRC_A:   src_val = reg_a_q;
            SRC_B:   src_val = reg_b_q;
            SRC_IN:  src_val = IN;
            default: src_val = 4'h0;
        endcase
    end

    assign sum = {1'b0, src_val} + {1'b0, imm};

    // JNC tests the carry left by the previously executed instruction.
    assign jump_taken = (dst_sel == DST_JMP) || ((dst_sel == DST_JNC) && !carry_q);

    always_comb begin
        pc_d    = pc_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        out_d   = out_q;
        carry_d = carry_q;
        if (EN) begin
            // Undefined opcodes clear the flag regardless of the immediate field.
            carry_d = (dst_sel == DST_NONE) ? 1'b0 : sum[4];
            pc_d    = jump_taken ? sum[3:0] : pc_q + 4'h1;
            if (dst_sel == DST_A)   reg_a_d = sum[3:0];
            if (dst_sel == DST_B)   reg_b_d = sum[3:0];
            if (dst_sel == DST_OUT) out_d   = sum[3:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            pc_q    <= RESET_PC;
            reg_a_q <= 4'h0;
            reg_b_q <= 4'h0;
            out_q   <= 4'h0;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign A     = pc_q;
    assign OUT   = out_q;
    assign REG_A = reg_a_q;
    assign REG_B = reg_b_q;
    assign CARRY = carry_q;

endmodule
